// File: rtl/output_drain_ctrl.sv
// rtl/output_drain_ctrl.sv - drains a programmed output-buffer address range into a valid/ready stream
// Sequential reads feed a 2-entry skid FIFO so the 1-cycle read latency never drops or repeats a word.
module output_drain_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 256,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  buf_rd_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   beat_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            fifo_count;

  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;

  assign pop       = m_valid & m_ready;
  assign push      = buf_rd_valid & inflight;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};

  // Words already read but not yet consumed may never exceed the FIFO's two slots.
  assign buf_rd_en   = (state == S_RUN) && (issue_cnt != '0) &&
                       (occupancy < (3'd2 + {2'b00, pop}));
  assign buf_rd_addr = rd_ptr;

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_mem[rd_idx];
  assign m_last  = m_valid && (beat_cnt == (ADDR_WIDTH+1)'(1));
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_ptr    <= base_addr;
            issue_cnt <= length;
            beat_cnt  <= length;
            state     <= (length == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (buf_rd_en) begin
            rd_ptr    <= (rd_ptr == ADDR_WIDTH'(BUFFER_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            issue_cnt <= issue_cnt - 1'b1;
          end
          if (pop && m_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      // A return with nothing outstanding (e.g. straddling reset release) is dropped.
      if (buf_rd_en)  inflight <= 1'b1;
      else if (push)  inflight <= 1'b0;

      if (push) begin
        fifo_mem[wr_idx] <= buf_rd_data;
        wr_idx           <= ~wr_idx;
      end
      if (pop) begin
        rd_idx   <= ~rd_idx;
        beat_cnt <= beat_cnt - 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  no_fifo_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == 2'd2));

endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb/tb_output_drain_ctrl.sv - randomized self-checking bench for output_drain_ctrl
// Expected beats come from a queue-level model: word i of a transfer is mem[(base+i) mod 256].
module tb_output_drain_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, buf_rd_en, buf_rd_valid, m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data, m_data;

  logic [DW-1:0] mem [DEPTH];
  logic          model_valid = 1'b0;
  logic [DW-1:0] model_data = '0;
  logic          stray = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  logic [AW-1:0] obs_addr[$];
  int first_valid, done_cyc, done_cnt, en_viol, stall_viol, busy_after, timed_out;
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  output_drain_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .buf_rd_valid(buf_rd_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    model_valid <= buf_rd_en;
    model_data  <= mem[buf_rd_addr];
  end
  assign buf_rd_valid = model_valid | stray;
  assign buf_rd_data  = model_data;

  // Runs one transfer and records what the DUT did; cycle 0 is the cycle after the start edge.
  task automatic run_xfer(input logic [AW-1:0] base, input int len, input int mode, input bit inject_start);
    int issued, popped;
    bit pop, stalled;
    logic [DW-1:0] prev_data;
    obs_data.delete(); obs_last.delete(); obs_addr.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; en_viol = 0; stall_viol = 0;
    busy_after = -1; timed_out = 1; issued = 0; popped = 0; stalled = 0; prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (c < 6) ? pat[c][0] : 1'($urandom_range(0, 1));
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject_start && c == 3) begin
        start = 1'b1; base_addr = 8'h00; length = 9'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      pop = m_valid && m_ready;
      if (stalled && (!m_valid || m_data !== prev_data)) stall_viol++;
      stalled = m_valid && !m_ready;
      prev_data = m_data;
      if (buf_rd_en) begin
        if (issued - popped - int'(pop) >= 2) en_viol++;
        obs_addr.push_back(buf_rd_addr);
        issued++;
      end
      if (m_valid && first_valid < 0) first_valid = c;
      if (pop) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_last);
        popped++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && c == done_cyc + 2) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, buf_rd_en, m_valid, m_last} !== 5'b0 || buf_rd_addr !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h required all 0",
               busy, done, buf_rd_en, m_valid, m_last, buf_rd_addr, m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_xfer(8'h10, 4, 0, 0);
    checks++;
    if (timed_out != 0 || obs_data.size() != 4) begin
      failures++; $display("FAIL basic_beats: got %0d beats timeout=%0d required 4", obs_data.size(), timed_out);
    end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      checks++;
      if (obs_data[i] !== 16'h0110 + 16'(i) || obs_last[i] !== (i == 3)) begin
        failures++;
        $display("FAIL basic_beat%0d: data=%h last=%b required data=%h last=%b", i, obs_data[i], obs_last[i], 16'h0110 + 16'(i), i == 3);
      end
    end
    checks++;
    if (first_valid != 2 || done_cyc != 6 || done_cnt != 1 || busy_after != 0) begin
      failures++;
      $display("FAIL basic_timing: first_valid=%0d done_cyc=%0d done_cnt=%0d busy_after=%0d required 2 6 1 0",
               first_valid, done_cyc, done_cnt, busy_after);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_xfer(8'hFE, 4, 2, 0);
    checks++;
    if (timed_out != 0 || obs_data.size() != 4 || obs_addr.size() != 4) begin
      failures++; $display("FAIL wrap_count: beats=%0d reads=%0d required 4 4", obs_data.size(), obs_addr.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== mem[exp_addr[i]] || obs_last[i] !== (i == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d: addr=%h data=%h last=%b required addr=%h data=%h last=%b",
                 i, obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], mem[exp_addr[i]], i == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] base;
    int bad;
    for (int rep = 0; rep < 3; rep++) begin
      base = AW'($urandom);
      bad = 0;
      run_xfer(base, 6, 1, 0);
      for (int i = 0; i < obs_data.size(); i++)
        if (obs_data[i] !== mem[AW'(base + 8'(i))] || obs_last[i] !== (i == 5)) bad++;
      checks++;
      if (timed_out != 0 || obs_data.size() != 6 || bad != 0) begin
        failures++; $display("FAIL bp_data: beats=%0d bad=%0d required 6 0", obs_data.size(), bad);
      end
      checks++;
      if (stall_viol != 0 || en_viol != 0) begin
        failures++; $display("FAIL bp_rules: stall_viol=%0d en_viol=%0d required 0 0", stall_viol, en_viol);
      end
    end
  endtask

  task automatic test_zero_and_ignore();
    logic [AW-1:0] base;
    int bad;
    run_xfer(8'h33, 0, 0, 0);
    checks++;
    if (timed_out != 0 || obs_addr.size() != 0 || first_valid != -1 || done_cyc != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL zero_len: reads=%0d first_valid=%0d done_cyc=%0d done_cnt=%0d required 0 -1 0 1",
               obs_addr.size(), first_valid, done_cyc, done_cnt);
    end
    base = AW'($urandom);
    bad = 0;
    run_xfer(base, 8, 0, 1);
    for (int i = 0; i < obs_data.size(); i++)
      if (obs_data[i] !== mem[AW'(base + 8'(i))]) bad++;
    checks++;
    if (timed_out != 0 || obs_data.size() != 8 || bad != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL ignore_start: beats=%0d bad=%0d done_cnt=%0d required 8 0 1", obs_data.size(), bad, done_cnt);
    end
  endtask

  task automatic test_full_range();
    int bad_addr, bad_data, bad_last;
    bad_addr = 0; bad_data = 0; bad_last = 0;
    run_xfer(8'h80, 256, 2, 0);
    for (int i = 0; i < obs_addr.size(); i++)
      if (obs_addr[i] !== AW'(8'h80 + 8'(i))) bad_addr++;
    for (int i = 0; i < obs_data.size(); i++) begin
      if (obs_data[i] !== mem[AW'(8'h80 + 8'(i))]) bad_data++;
      if (obs_last[i] !== (i == 255)) bad_last++;
    end
    checks++;
    if (timed_out != 0 || obs_data.size() != 256 || obs_addr.size() != 256) begin
      failures++; $display("FAIL full_count: beats=%0d reads=%0d required 256 256", obs_data.size(), obs_addr.size());
    end
    checks++;
    if (bad_addr != 0 || bad_data != 0 || bad_last != 0 || en_viol != 0 || stall_viol != 0) begin
      failures++;
      $display("FAIL full_content: bad_addr=%0d bad_data=%0d bad_last=%0d en_viol=%0d stall_viol=%0d required all 0",
               bad_addr, bad_data, bad_last, en_viol, stall_viol);
    end
  endtask

  task automatic test_reset_mid();
    int popped, saw_done;
    logic [AW-1:0] base;
    popped = 0; saw_done = 0;
    @(posedge clk); #1;
    m_ready = 1'b1; start = 1'b1; base_addr = 8'h40; length = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && popped < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) popped++;
      if (done) saw_done++;
      if (popped < 3) begin @(posedge clk); #1; end
    end
    checks++;
    if (popped != 3) begin
      failures++; $display("FAIL rstmid_progress: beats=%0d required 3", popped);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, buf_rd_en, m_valid, m_last} !== 5'b0 || buf_rd_addr !== '0 || m_data !== '0 || saw_done != 0) begin
      failures++;
      $display("FAIL rstmid_outputs: busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h early_done=%0d required all 0",
               busy, done, buf_rd_en, m_valid, m_last, buf_rd_addr, m_data, saw_done);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_stray: valid=%b busy=%b done=%b required 0 0 0", m_valid, busy, done);
    end
    base = AW'($urandom);
    run_xfer(base, 2, 2, 0);
    checks++;
    if (timed_out != 0 || obs_data.size() != 2 || done_cnt != 1) begin
      failures++; $display("FAIL rstmid_restart_count: beats=%0d done_cnt=%0d required 2 1", obs_data.size(), done_cnt);
    end
    for (int i = 0; i < obs_data.size() && i < 2; i++) begin
      checks++;
      if (obs_data[i] !== mem[AW'(base + 8'(i))] || obs_last[i] !== (i == 1)) begin
        failures++;
        $display("FAIL rstmid_restart_beat%0d: data=%h last=%b required data=%h last=%b",
                 i, obs_data[i], obs_last[i], mem[AW'(base + 8'(i))], i == 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k + 16'h0100);
    test_reset();
    test_basic();
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
    test_wrap();
    test_backpressure();
    test_zero_and_ignore();
    test_full_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
